uart_tx_frame_ctrl: RTL and testbench

Parametrised UART transmit engine and successor to the fixed 8-bit TX FSM.
- Integrates frame FSM, serializer, parity generator and output select.
- Adds configurable data width, even/odd parity, 1 or 2 stop bits, back-to-back frames without an idle bit, and an explicit accept handshake.
- Sits in the TX clock domain; one CLK cycle = one bit time. Data is fed by the TX-side async FIFO read logic.

---
 rtl/uart_tx_pkg.sv | 33 +++
 rtl/uart_tx_serializer.sv | 47 ++++
 rtl/uart_tx_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX frame controller: state encoding,
// parity-type and stop-count constants.
// Optional build macro: UART_TX_BREAK_EN adds the BREAK state.
package uart_tx_pkg;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_START  = 3'd1;
  localparam logic [2:0] ENC_DATA   = 3'd2;
  localparam logic [2:0] ENC_PARITY = 3'd3;
  localparam logic [2:0] ENC_STOP1  = 3'd4;
  localparam logic [2:0] ENC_STOP2  = 3'd5;
  localparam logic [2:0] ENC_BREAK  = 3'd6;

  typedef enum logic [2:0] {
    StIdle   = ENC_IDLE,
    StStart  = ENC_START,
    StData   = ENC_DATA,
    StParity = ENC_PARITY,
    StStop1  = ENC_STOP1,
    StStop2  = ENC_STOP2
`ifdef UART_TX_BREAK_EN
    ,
    StBreak  = ENC_BREAK
`endif
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and data-bit counter for the UART TX engine.
// o_bit is the next payload bit to drive; the register shifts as it is consumed.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic                  i_shift_en,
  input  logic                  i_cnt_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bit,
  output logic                  o_done
);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_last;

  assign w_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign o_bit  = r_shift[0];
  assign o_done = w_last;

  // Shift register: load on accept, shift LSB-first as each data bit is driven.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
    end else if (i_shift_en) begin
      r_shift <= r_shift >> 1;
    end
  end

  // Bit counter: counts data-state cycles and wraps to 0 when leaving DATA.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_cnt_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// Parametrised UART transmit engine: frame FSM, parity and output select.
// One CLK cycle is one bit time. TX_OUT and BUSY are registered from the
// state being entered, so back-to-back frames keep BUSY high.
// Optional build macro: UART_TX_BREAK_EN adds BREAK_REQ and a line-break state.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic                  BREAK_REQ,
`endif
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  ACCEPT
);

  tx_state_e r_state;
  tx_state_e w_state_nxt;
  tx_state_e w_after_stop;

  logic r_tx;
  logic w_tx_nxt;
  logic r_busy;
  logic r_par_en;
  logic r_par_bit;
  logic r_stop2;

  logic w_last_stop;
  logic w_can_take;
  logic w_brk_go;
  logic w_ser_bit;
  logic w_ser_done;

  assign w_last_stop = ((r_state == StStop1) && (r_stop2 == STOP_ONE)) || (r_state == StStop2);
  assign w_can_take  = (r_state == StIdle) || w_last_stop;

`ifdef UART_TX_BREAK_EN
  localparam int unsigned BRK_W = $clog2(DATA_WIDTH + 5);

  logic [BRK_W-1:0] r_brk_cnt;
  logic [BRK_W-1:0] w_brk_load;

  // Break wins over data when both are requested in an accepting cycle.
  assign w_brk_go   = w_can_take & BREAK_REQ;
  // Break length minus one: 1 + DATA_WIDTH + PAR_EN + 1 + STOP2 cycles total.
  assign w_brk_load = BRK_W'(DATA_WIDTH + 1) + BRK_W'(PAR_EN) + BRK_W'(STOP2);

  // Break duration counter, loaded from the live config on entry.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_brk_cnt <= '0;
    end else if (w_brk_go) begin
      r_brk_cnt <= w_brk_load;
    end else if ((r_state == StBreak) && (r_brk_cnt != '0)) begin
      r_brk_cnt <= r_brk_cnt - 1'b1;
    end
  end
`else
  assign w_brk_go = 1'b0;
`endif

  assign ACCEPT = DATA_VALID & w_can_take & ~w_brk_go;
  assign TX_OUT = r_tx;
  assign BUSY   = r_busy;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_serializer (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (ACCEPT),
    .i_shift_en (w_state_nxt == StData),
    .i_cnt_en   (r_state == StData),
    .i_data     (P_DATA),
    .o_bit      (w_ser_bit),
    .o_done     (w_ser_done)
  );

  // Next-state decode and selection of the bit for the state being entered.
  always_comb begin
    w_state_nxt  = r_state;
    w_tx_nxt     = 1'b1;
    w_after_stop = ACCEPT ? StStart : StIdle;
`ifdef UART_TX_BREAK_EN
    if (w_brk_go) begin
      w_after_stop = StBreak;
    end
`endif
    unique case (r_state)
      StIdle:   w_state_nxt = w_after_stop;
      StStart:  w_state_nxt = StData;
      StData: begin
        if (w_ser_done) begin
          w_state_nxt = r_par_en ? StParity : StStop1;
        end
      end
      StParity: w_state_nxt = StStop1;
      StStop1:  w_state_nxt = (r_stop2 == STOP_TWO) ? StStop2 : w_after_stop;
      StStop2:  w_state_nxt = w_after_stop;
`ifdef UART_TX_BREAK_EN
      StBreak:  w_state_nxt = (r_brk_cnt == '0) ? StStop1 : StBreak;
`endif
      default:  w_state_nxt = StIdle;
    endcase

    unique case (w_state_nxt)
      StStart:  w_tx_nxt = 1'b0;
      StData:   w_tx_nxt = w_ser_bit;
      StParity: w_tx_nxt = r_par_bit;
`ifdef UART_TX_BREAK_EN
      StBreak:  w_tx_nxt = 1'b0;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // State, line and busy registers; reset aborts any frame with the line high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= StIdle;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != StIdle);
    end
  end

  // Frame config latched on accept so mid-frame changes have no effect.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_stop2   <= STOP_ONE;
    end else if (ACCEPT) begin
      r_par_en  <= PAR_EN;
      r_par_bit <= (PAR_TYP == PAR_EVEN) ? ^P_DATA : ~^P_DATA;
      r_stop2   <= STOP2;
    end else if (w_brk_go) begin
      r_par_en  <= PAR_EN;
      r_stop2   <= STOP2;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl. The reference model is a queue
// of line bits still owed by the transmitter; a new frame may be taken
// whenever that queue is empty.
module tb_uart_tx_frame_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic          dv = 1'b0;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          stop2 = 1'b0;
  logic          brk = 1'b0;
  logic          tx;
  logic          busy;
  logic          acc;

  int checks = 0;
  int errors = 0;
  bit q[$];
  bit last_acc;

  always #5 clk = ~clk;

  uart_tx_frame_ctrl #(
    .DATA_WIDTH (DW)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .P_DATA     (p_data),
    .DATA_VALID (dv),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .STOP2      (stop2),
`ifdef UART_TX_BREAK_EN
    .BREAK_REQ  (brk),
`endif
    .TX_OUT     (tx),
    .BUSY       (busy),
    .ACCEPT     (acc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [DW-1:0] d, input bit pe, input bit pt,
                                     input bit s2);
    int ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    // Even parity makes the total count of ones even; odd makes it odd.
    if (pe) q.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
  endfunction

  function automatic void push_break(input bit pe, input bit s2);
    for (int i = 0; i < 1 + DW + int'(pe) + 1 + int'(s2); i++) q.push_back(1'b0);
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
  endfunction

  // One bit time: check ACCEPT before the edge, then the line after it.
  task automatic tick();
    bit go_brk, exp_acc, etx, ebusy;
    logic [DW-1:0] d;
    bit pe, pt, s2;
    go_brk  = brk && (q.size() == 0);
    exp_acc = dv && !go_brk && (q.size() == 0);
    d = p_data; pe = par_en; pt = par_typ; s2 = stop2;
    #1;
    check("accept", acc, exp_acc);
    last_acc = exp_acc;
    @(posedge clk);
    if (exp_acc) push_frame(d, pe, pt, s2);
    if (go_brk) push_break(pe, s2);
    #1;
    if (q.size() > 0) begin
      etx = q.pop_front();
      ebusy = 1'b1;
    end else begin
      etx = 1'b1;
      ebusy = 1'b0;
    end
    check("tx_out", tx, etx);
    check("busy", busy, ebusy);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    tick();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_accept", acc, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain 8N1 frame 0xA5
    p_data = 8'hA5; dv = 1'b1;
    tick();
    dv = 1'b0;
    repeat (11) tick();

    // Parity even then odd on 0x03
    p_data = 8'h03; par_en = 1'b1; par_typ = 1'b0; dv = 1'b1;
    tick();
    dv = 1'b0;
    drain();
    par_typ = 1'b1; dv = 1'b1;
    tick();
    dv = 1'b0;
    drain();

    // Two stop bits, DATA_VALID held: back-to-back 0x55 then 0xFF
    par_en = 1'b0; stop2 = 1'b1; p_data = 8'h55; dv = 1'b1;
    tick();
    p_data = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    dv = 1'b0;
    drain();

    // Config and data toggled mid-frame
    p_data = 8'($urandom); par_en = 1'b1; par_typ = 1'($urandom); stop2 = 1'b0; dv = 1'b1;
    tick();
    dv = 1'b0;
    for (int i = 0; i < 14; i++) begin
      p_data = 8'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
      stop2 = 1'($urandom);
      tick();
    end
    drain();

    // Randomized traffic with gaps and back-to-back frames
    for (int i = 0; i < 400; i++) begin
      dv = ($urandom_range(0, 2) != 0);
      p_data = 8'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
      stop2 = 1'($urandom);
      tick();
    end
    dv = 1'b0;
    drain();

    // Asynchronous reset during the 4th data bit of a 0x00 frame
    p_data = 8'h00; par_en = 1'b0; stop2 = 1'b0; dv = 1'b1;
    tick();
    dv = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    p_data = 8'h81; dv = 1'b1;
    tick();
    dv = 1'b0;
    drain();

`ifdef UART_TX_BREAK_EN
    // Break and data requested together in IDLE: break first, then the data
    p_data = 8'h3C; par_en = 1'b0; stop2 = 1'b0; dv = 1'b1; brk = 1'b1;
    tick();
    brk = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    dv = 1'b0;
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
